reg_file_sb: RTL and testbench

- Parametrised register file for the 5-stage pipelined MIPS core.
- Has NREAD registered read ports and one write port with write-to-read bypass.
- Register 0 is hardwired to zero.
- A per-register pending scoreboard lets decode detect RAW hazards on in-flight destinations.
- A dedicated PC register with its own write enable replaces the PC-in-register-31 scheme, so all general registers are architecturally visible.

---
 rtl/reg_file_sb.sv | 94 +++++++++
 tb/tb_reg_file_sb.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Register file with NREAD registered read ports, write-first bypass, a per-register
// pending scoreboard for RAW hazard detection, and a dedicated PC register.
module reg_file_sb #(
    parameter int                 DATA_W = 32,
    parameter int                 ADDR_W = 5,
    parameter int                 NREAD  = 2,
    parameter logic [DATA_W-1:0]  PC_RST = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_en,
    input  logic [NREAD*ADDR_W-1:0]    raddr,
    output logic [NREAD*DATA_W-1:0]    rdata,
    output logic [NREAD-1:0]           rpend,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       sb_set,
    input  logic [ADDR_W-1:0]          sb_addr,
    input  logic                       pc_write,
    input  logic [DATA_W-1:0]          pc_in,
    output logic [DATA_W-1:0]          pc_out,
    output logic                       any_pend
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_nxt;
    logic              wr_ok;
    logic              set_ok;

    assign wr_ok  = we && (waddr != '0);
    assign set_ok = sb_set && (sb_addr != '0);

    // Retiring write clears, issuing set marks; a set on the same edge wins.
    always_comb begin
        pend_nxt = pend;
        if (wr_ok) begin
            pend_nxt[waddr] = 1'b0;
        end
        if (set_ok) begin
            pend_nxt[sb_addr] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            pend     <= '0;
            any_pend <= 1'b0;
        end else begin
            if (wr_ok) begin
                regs[waddr] <= wdata;
            end
            pend     <= pend_nxt;
            any_pend <= |pend_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
            rpend <= '0;
        end else if (rd_en) begin
            for (int k = 0; k < NREAD; k++) begin
                if (raddr[k*ADDR_W +: ADDR_W] == '0) begin
                    rdata[k*DATA_W +: DATA_W] <= '0;
                    rpend[k]                  <= 1'b0;
                end else begin
                    if (wr_ok && (waddr == raddr[k*ADDR_W +: ADDR_W])) begin
                        rdata[k*DATA_W +: DATA_W] <= wdata;
                    end else begin
                        rdata[k*DATA_W +: DATA_W] <= regs[raddr[k*ADDR_W +: ADDR_W]];
                    end
                    rpend[k] <= pend_nxt[raddr[k*ADDR_W +: ADDR_W]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out <= PC_RST;
        end else if (pc_write) begin
            pc_out <= pc_in;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: bypass, scoreboard, x0 handling, stall hold, PC and reset.
module tb_reg_file_sb;

    localparam int          DATA_W = 32;
    localparam int          ADDR_W = 5;
    localparam int          NREAD  = 2;
    localparam logic [31:0] PC_RST = 32'hBFC0_0000;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    rd_en;
    logic [NREAD*ADDR_W-1:0] raddr;
    logic [NREAD*DATA_W-1:0] rdata;
    logic [NREAD-1:0]        rpend;
    logic                    we;
    logic [ADDR_W-1:0]       waddr;
    logic [DATA_W-1:0]       wdata;
    logic                    sb_set;
    logic [ADDR_W-1:0]       sb_addr;
    logic                    pc_write;
    logic [DATA_W-1:0]       pc_in;
    logic [DATA_W-1:0]       pc_out;
    logic                    any_pend;

    int checks = 0;
    int errors = 0;

    reg_file_sb #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD), .PC_RST(PC_RST)
    ) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .raddr(raddr), .rdata(rdata),
        .rpend(rpend), .we(we), .waddr(waddr), .wdata(wdata), .sb_set(sb_set),
        .sb_addr(sb_addr), .pc_write(pc_write), .pc_in(pc_in), .pc_out(pc_out),
        .any_pend(any_pend)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_raddr(input logic [4:0] a0, input logic [4:0] a1);
        raddr = {a1, a0};
    endtask

    initial begin
        rst = 1'b1; rd_en = 1'b1; raddr = '0; we = 1'b0; waddr = '0; wdata = '0;
        sb_set = 1'b0; sb_addr = '0; pc_write = 1'b0; pc_in = '0;
        step();
        chk("rst_rdata", rdata[31:0], 32'h0);
        chk("rst_rpend", {30'b0, rpend}, 32'h0);
        chk("rst_pc", pc_out, PC_RST);
        chk("rst_any_pend", {31'b0, any_pend}, 32'h0);

        // 1: x0 and x31 read zero
        rst = 1'b0;
        set_raddr(5'd0, 5'd31);
        step();
        chk("t1_rdata0", rdata[31:0], 32'h0);
        chk("t1_rdata1", rdata[63:32], 32'h0);
        chk("t1_rpend", {30'b0, rpend}, 32'h0);

        // 2: bypass on write to x8, then port1 reads x8
        we = 1'b1; waddr = 5'd8; wdata = 32'h8;
        set_raddr(5'd8, 5'd31);
        step();
        chk("t2_bypass", rdata[31:0], 32'h8);
        chk("t2_p1_x31", rdata[63:32], 32'h0);
        we = 1'b0;
        set_raddr(5'd8, 5'd8);
        step();
        chk("t2_p1_x8", rdata[63:32], 32'h8);
        chk("t2_p0_x8", rdata[31:0], 32'h8);

        // 3: scoreboard set then clear by write
        sb_set = 1'b1; sb_addr = 5'd10;
        set_raddr(5'd10, 5'd0);
        step();
        chk("t3_rpend_set", {31'b0, rpend[0]}, 32'h1);
        chk("t3_any_set", {31'b0, any_pend}, 32'h1);
        sb_set = 1'b0;
        step();
        chk("t3_rpend_hold", {31'b0, rpend[0]}, 32'h1);
        we = 1'b1; waddr = 5'd10; wdata = 32'h5;
        step();
        chk("t3_rdata", rdata[31:0], 32'h5);
        chk("t3_rpend_clr", {31'b0, rpend[0]}, 32'h0);
        chk("t3_any_clr", {31'b0, any_pend}, 32'h0);

        // 4: same-edge set and write, then x0 write/set ignored
        sb_set = 1'b1; sb_addr = 5'd17; we = 1'b1; waddr = 5'd17; wdata = 32'h6;
        set_raddr(5'd17, 5'd0);
        step();
        chk("t4_x17_data", rdata[31:0], 32'h6);
        chk("t4_x17_pend", {31'b0, rpend[0]}, 32'h1);
        sb_addr = 5'd0; waddr = 5'd0; wdata = 32'hFFFF;
        set_raddr(5'd0, 5'd17);
        step();
        chk("t4_x0_bypass", rdata[31:0], 32'h0);
        chk("t4_x0_pend", {31'b0, rpend[0]}, 32'h0);
        chk("t4_p1_x17_data", rdata[63:32], 32'h6);
        chk("t4_p1_x17_pend", {31'b0, rpend[1]}, 32'h1);
        sb_set = 1'b0; we = 1'b0;
        step();
        chk("t4_x0_stored", rdata[31:0], 32'h0);
        chk("t4_any_x17", {31'b0, any_pend}, 32'h1);
        we = 1'b1; waddr = 5'd17; wdata = 32'h6;
        step();
        chk("t4_any_clr", {31'b0, any_pend}, 32'h0);

        // 5: stall holds read outputs
        waddr = 5'd19; wdata = 32'h5;
        set_raddr(5'd8, 5'd0);
        step();
        chk("t5_pre", rdata[31:0], 32'h8);
        we = 1'b0; rd_en = 1'b0;
        set_raddr(5'd19, 5'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_hold", rdata[31:0], 32'h8);
        end
        rd_en = 1'b1;
        step();
        chk("t5_resume", rdata[31:0], 32'h5);

        // 6: PC load/hold, then reset discards pending and overrides inputs
        pc_write = 1'b1; pc_in = 32'h40;
        step();
        chk("t6_pc_load", pc_out, 32'h40);
        pc_write = 1'b0; pc_in = 32'h44;
        step();
        chk("t6_pc_hold", pc_out, 32'h40);
        sb_set = 1'b1; sb_addr = 5'd9;
        set_raddr(5'd9, 5'd9);
        step();
        chk("t6_x9_pend", {30'b0, rpend}, 32'h3);
        chk("t6_any", {31'b0, any_pend}, 32'h1);
        rst = 1'b1; sb_set = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'hAA; pc_write = 1'b1;
        step();
        chk("t6_rst_pc", pc_out, PC_RST);
        chk("t6_rst_rdata", rdata[31:0], 32'h0);
        chk("t6_rst_rpend", {30'b0, rpend}, 32'h0);
        chk("t6_rst_any", {31'b0, any_pend}, 32'h0);
        rst = 1'b0; sb_set = 1'b0; we = 1'b0; pc_write = 1'b0;
        step();
        chk("t6_x9_data", rdata[31:0], 32'h0);
        chk("t6_x9_nopend", {30'b0, rpend}, 32'h0);
        chk("t6_pc_after", pc_out, PC_RST);
        we = 1'b1; waddr = 5'd9; wdata = 32'h7;
        step();
        chk("t6_x9_wr_p0", rdata[31:0], 32'h7);
        chk("t6_x9_wr_p1", rdata[63:32], 32'h7);
        we = 1'b0;
        step();
        chk("t6_x9_stored", rdata[31:0], 32'h7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
